// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_t  : ratio-change FSM encoding (IDLE / PENDING)
//   MIN_DIV  : smallest legal divide ratio; smaller requests are clamped
//   half_up  : high-phase length (N+1)>>1. Computed in 32 bits, so the
//              caller keeps DIV_W+1 bits and N = 2^DIV_W-1 cannot overflow.
package clk_div_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [31:0] half_up(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_gen.sv
// Programmable clock divider with a glitch-free runtime ratio change.
// Ports:
//   clk      in   source clock
//   rst      in   asynchronous active-high reset
//   div_req  in   request to load div_val (pulse or level)
//   div_val  in   requested ratio N (values below 2 are clamped to 2)
//   div_ack  out  one-cycle pulse in the first cycle of the new period
//   div_err  out  one-cycle pulse after a clamped request is accepted
//   busy     out  a ratio change is pending
//   cur_div  out  ratio currently in effect
//   clk_out  out  divided clock, flop driven, high for (N+1)>>1 cycles
//   clk_en   out  one-cycle pulse in the cycle where clk_out rises
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             clk_en
);

  state_t           state, state_next;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend;
  logic [DIV_W-1:0] clamped;
  logic [DIV_W:0]   hi;
  logic             wrap;
  logic             too_small;
  logic             accept;
  logic             apply;

  assign wrap      = (cnt == cur_div - DIV_W'(1));
  assign too_small = (div_val < DIV_W'(MIN_DIV));
  assign clamped   = too_small ? DIV_W'(MIN_DIV) : div_val;
  assign hi        = (DIV_W+1)'(half_up(32'(cur_div)));
  assign busy      = (state == PENDING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A request accepted on a wrap edge is not applied there: the FSM is
  // still IDLE on that edge, so the switch waits for the next wrap.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        if (div_req) begin
          accept     = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (wrap) begin
          apply      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // clk_out is registered from the pre-edge count, so the first rise lands
  // on the first edge after reset, and the wrap edge always drives the last
  // low cycle with the old ratio before cur_div switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cur_div <= DIV_W'(DEFAULT_DIV);
      pend    <= '0;
      clk_out <= 1'b0;
      clk_en  <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + DIV_W'(1);
      clk_out <= ({1'b0, cnt} < hi);
      clk_en  <= (cnt == '0);
      div_ack <= apply;
      div_err <= accept && too_small;
      if (accept) pend    <= clamped;
      if (apply)  cur_div <= pend;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       div_req = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_ack, div_err, busy, clk_out, clk_en;
  logic [7:0] cur_div;

  clk_div_gen #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .busy    (busy),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .clk_en  (clk_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clk_out;
    logic       clk_en;
    logic       div_ack;
    logic       div_err;
    logic       busy;
    logic [7:0] cur_div;
  } obs_t;

  obs_t sb[$];
  obs_t seen[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: ratio, position in period, pending flag and value.
  int m_n, m_p, m_pend;
  bit m_busy;

  function automatic obs_t sample();
    obs_t o;
    o.clk_out = clk_out;
    o.clk_en  = clk_en;
    o.div_ack = div_ack;
    o.div_err = div_err;
    o.busy    = busy;
    o.cur_div = cur_div;
    return o;
  endfunction

  task automatic model_reset();
    m_n = 4; m_p = 0; m_pend = 0; m_busy = 0;
    sb.delete();
    seen.delete();
  endtask

  task automatic model_edge(input logic req, input int val);
    obs_t e;
    bit   last;
    last      = (m_p == m_n - 1);
    e.clk_out = (m_p < (m_n + 1) / 2);
    e.clk_en  = (m_p == 0);
    e.div_ack = m_busy && last;
    e.div_err = !m_busy && req && (val < 2);
    if (!m_busy && req) begin
      m_busy = 1;
      m_pend = (val < 2) ? 2 : val;
    end else if (m_busy && last) begin
      m_n    = m_pend;
      m_busy = 0;
    end
    m_p       = last ? 0 : m_p + 1;
    e.busy    = m_busy;
    e.cur_div = 8'(m_n);
    sb.push_back(e);
  endtask

  task automatic tick(input logic req, input logic [7:0] val);
    div_req = req;
    div_val = val;
    @(posedge clk);
    model_edge(req, int'(val));
    #1;
    seen.push_back(sample());
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (!seen[$].div_ack && n < limit) begin
      tick(1'b0, 8'd0);
      n++;
    end
  endtask

  task automatic test_reset();
    obs_t got, exp;
    logic [7:0] pat_out, pat_en;
    pat_out = 8'b0011_0011;
    pat_en  = 8'b0001_0001;
    rst = 1'b1;
    div_req = 1'b0;
    model_reset();
    @(negedge clk); #1;
    checks++;
    if ({clk_out, clk_en, div_ack, div_err, busy, cur_div} !== 13'h004) begin
      errors++;
      $display("FAIL reset_vals got=%b exp=%b",
               {clk_out, clk_en, div_ack, div_err, busy, cur_div}, 13'h004);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) tick(1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seen[i].clk_out !== pat_out[i] || seen[i].clk_en !== pat_en[i]) begin
        errors++;
        $display("FAIL reset_pattern[%0d] got=%b%b exp=%b%b", i,
                 seen[i].clk_out, seen[i].clk_en, pat_out[i], pat_en[i]);
      end
    end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_reset got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_odd();
    obs_t got, exp;
    int n, base;
    tick(1'b1, 8'd5);
    checks++;
    if (seen[$].busy !== 1'b1) begin errors++; $display("FAIL odd_busy got=%b exp=1", seen[$].busy); end
    wait_ack(20, n);
    checks++;
    if (!seen[$].div_ack || n < 1 || n > 4) begin
      errors++; $display("FAIL odd_latency got=%0d exp=1..4 ack=%b", n, seen[$].div_ack);
    end
    base = seen.size();
    repeat (10) tick(1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (seen[base+i].clk_out !== ((i % 5) < 3)) begin
        errors++; $display("FAIL odd_pattern[%0d] got=%b exp=%b", i, seen[base+i].clk_out, (i % 5) < 3);
      end
    end
    checks++;
    if (seen[$].cur_div !== 8'd5) begin errors++; $display("FAIL odd_cur_div got=%0d exp=5", seen[$].cur_div); end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_odd got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_clamp();
    obs_t got, exp;
    int n, base;
    for (int v = 0; v < 2; v++) begin
      tick(1'b1, 8'(v));
      checks++;
      if (seen[$].div_err !== 1'b1) begin errors++; $display("FAIL clamp_err[%0d] got=%b exp=1", v, seen[$].div_err); end
      wait_ack(20, n);
      checks++;
      if (!seen[$].div_ack) begin errors++; $display("FAIL clamp_timeout[%0d] got=0 exp=1", v); end
    end
    base = seen.size();
    repeat (6) tick(1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seen[base+i].clk_out !== ((i % 2) == 0) || seen[base+i].cur_div !== 8'd2) begin
        errors++; $display("FAIL clamp_pattern[%0d] got=%b/%0d exp=%b/2", i,
                           seen[base+i].clk_out, seen[base+i].cur_div, (i % 2) == 0);
      end
    end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_clamp got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int n, acks, errs;
    tick(1'b1, 8'd6);
    tick(1'b1, 8'd3);
    wait_ack(20, n);
    checks++;
    if (!seen[$].div_ack) begin errors++; $display("FAIL busy_timeout got=0 exp=1"); end
    repeat (12) tick(1'b0, 8'd0);
    acks = 0; errs = 0;
    foreach (seen[i]) begin
      acks += int'(seen[i].div_ack);
      errs += int'(seen[i].div_err);
    end
    checks++;
    if (acks != 1 || errs != 0) begin errors++; $display("FAIL busy_pulses got=%0d/%0d exp=1/0", acks, errs); end
    checks++;
    if (seen[$].cur_div !== 8'd6) begin errors++; $display("FAIL busy_cur_div got=%0d exp=6", seen[$].cur_div); end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_busy got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    int n, base;
    tick(1'b1, 8'd4);
    wait_ack(20, n);
    while (m_p != m_n - 1) tick(1'b0, 8'd0);
    tick(1'b1, 8'd3);
    wait_ack(20, n);
    checks++;
    if (!seen[$].div_ack || n != 4) begin
      errors++; $display("FAIL wrap_latency got=%0d exp=4 ack=%b", n, seen[$].div_ack);
    end
    base = seen.size();
    repeat (9) tick(1'b0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seen[base+i].clk_out !== ((i % 3) < 2)) begin
        errors++; $display("FAIL wrap_pattern[%0d] got=%b exp=%b", i, seen[base+i].clk_out, (i % 3) < 2);
      end
    end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_wrap got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_reset_pending();
    obs_t got, exp;
    int acks;
    tick(1'b1, 8'd7);
    checks++;
    if (seen[$].busy !== 1'b1) begin errors++; $display("FAIL rstp_busy got=%b exp=1", seen[$].busy); end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_rstp got=%h exp=%h", got, exp); end
    end
    div_req = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({div_ack, busy, cur_div} !== 10'h004) begin
      errors++; $display("FAIL rstp_vals got=%b exp=%b", {div_ack, busy, cur_div}, 10'h004);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) tick(1'b0, 8'd0);
    acks = 0;
    foreach (seen[i]) acks += int'(seen[i].div_ack);
    checks++;
    if (acks != 0 || seen[$].cur_div !== 8'd4) begin
      errors++; $display("FAIL rstp_after got=%0d/%0d exp=0/4", acks, seen[$].cur_div);
    end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_rstp2 got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_max();
    obs_t got, exp;
    int n, base, hi_run, ones;
    bit in_run;
    tick(1'b1, 8'd255);
    wait_ack(20, n);
    checks++;
    if (!seen[$].div_ack) begin errors++; $display("FAIL max_timeout got=0 exp=1"); end
    base = seen.size();
    repeat (255) tick(1'b0, 8'd0);
    hi_run = 0; ones = 0; in_run = 1;
    for (int i = 0; i < 255; i++) begin
      if (seen[base+i].clk_out === 1'b1) begin
        ones++;
        if (in_run) hi_run++;
      end else begin
        in_run = 0;
      end
    end
    checks++;
    if (hi_run != 128 || ones != 128) begin
      errors++; $display("FAIL max_duty got=%0d/%0d exp=128/128", hi_run, ones);
    end
    tick(1'b0, 8'd0);
    checks++;
    if (seen[$].clk_out !== 1'b1 || seen[$].clk_en !== 1'b1) begin
      errors++; $display("FAIL max_restart got=%b%b exp=11", seen[$].clk_out, seen[$].clk_en);
    end
    while (seen.size() > 0) begin
      got = seen.pop_front(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sb_max got=%h exp=%h", got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_odd();
    test_clamp();
    test_back_to_back();
    test_wrap();
    test_reset_pending();
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
